// File: rtl/spectrum_accumulator_if.sv
// Sample-in / final-sum-out bundle for the spectrum accumulator.
// master drives pulse data and control; slave (the accumulator) drives results.
interface spectrum_accumulator_if #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 9,
  parameter int unsigned ACC_W = 48
);
  logic             Capture_En;
  logic             data_valid_i;
  logic [DW-1:0]    data_i;
  logic [15:0]      Pulse_counts;
  logic             is_first_pls;
  logic [15:0]      Pulse_num;
  logic             acc_valid_o;
  logic [AW-1:0]    acc_addr_o;
  logic [ACC_W-1:0] acc_data_o;
  logic             acc_done_o;
  logic             busy_o;
  logic             ovf_o;

  modport master (
    output Capture_En, data_valid_i, data_i, Pulse_counts, is_first_pls, Pulse_num,
    input  acc_valid_o, acc_addr_o, acc_data_o, acc_done_o, busy_o, ovf_o
  );

  modport slave (
    input  Capture_En, data_valid_i, data_i, Pulse_counts, is_first_pls, Pulse_num,
    output acc_valid_o, acc_addr_o, acc_data_o, acc_done_o, busy_o, ovf_o
  );
endinterface

// File: rtl/spectrum_accumulator.sv
// Per-bin accumulation of pulse spectra over Pulse_num pulses. Each beat reads its bin,
// adds (or overwrites on the first pulse), saturates and writes back; sums produced during
// the final pulse are streamed out two cycles after their input beat.
module spectrum_accumulator #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 9,
  parameter int unsigned ACC_W = 48
) (
  input logic                    clk,
  input logic                    rst,
  spectrum_accumulator_if.slave  bus
);

  // Sum width wide enough for either operand plus a carry.
  localparam int unsigned SW = ((DW > ACC_W) ? DW : ACC_W) + 1;
  localparam logic [SW-1:0] SAT_MAX = SW'({ACC_W{1'b1}});

  typedef enum logic [1:0] {StIdle, StAccum, StLast, StDone} state_t;

  state_t           state_q, state_d;
  logic             dv_q;
  logic [AW:0]      addr_cnt_q;     // MSB set once the pulse has run past the last bin
  logic [15:0]      pnum_q;
  logic             s1_valid_q, s1_first_q, s1_final_q;
  logic [AW-1:0]    s1_addr_q;
  logic [DW-1:0]    s1_data_q;
  logic [ACC_W-1:0] rd_q;
  logic [ACC_W-1:0] mem [(1 << AW)];
  logic             acc_valid_q, done_q, ovf_q;
  logic [AW-1:0]    acc_addr_q;
  logic [ACC_W-1:0] acc_data_q;

  logic             eligible, accept, drop, first_beat, beat_final, sat, out_fire;
  logic [15:0]      pnum_in;
  logic [SW-1:0]    sum_ext;
  logic [ACC_W-1:0] sum_val;

  // Beat qualification and sum formation for the stage-1 beat.
  always_comb begin
    eligible   = bus.Capture_En && bus.data_valid_i && (state_q != StDone);
    accept     = eligible && !addr_cnt_q[AW];
    drop       = eligible && addr_cnt_q[AW];
    first_beat = bus.data_valid_i && !dv_q;
    pnum_in    = (bus.Pulse_num == 16'd0) ? 16'd1 : bus.Pulse_num;
    sum_ext    = s1_first_q ? SW'(s1_data_q) : SW'(rd_q) + SW'(s1_data_q);
    sat        = sum_ext > SAT_MAX;
    sum_val    = sat ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
    out_fire   = s1_valid_q && s1_final_q && bus.Capture_En;
  end

  // Next-state logic; beat_final marks beats whose sums must be presented.
  always_comb begin
    state_d    = state_q;
    beat_final = (state_q == StLast);
    case (state_q)
      StIdle: begin
        if (bus.Capture_En && bus.data_valid_i) begin
          if (pnum_in == 16'd1) begin
            state_d    = StLast;
            beat_final = 1'b1;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StAccum: begin
        if (first_beat && (bus.Pulse_counts == pnum_q - 16'd1)) begin
          state_d    = StLast;
          beat_final = 1'b1;
        end
      end
      // Pulse finished and nothing left in flight.
      StLast:  if (!bus.data_valid_i && !dv_q && !s1_valid_q) state_d = StDone;
      StDone:  ;
      default: state_d = StIdle;
    endcase
    if (!bus.Capture_En) state_d = StIdle;
  end

  // State, address counter, pipeline stage 1 and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      dv_q        <= 1'b0;
      addr_cnt_q  <= '0;
      pnum_q      <= 16'd1;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_final_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_data_q   <= '0;
      acc_valid_q <= 1'b0;
      acc_addr_q  <= '0;
      acc_data_q  <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      dv_q    <= bus.data_valid_i;
      if (state_q == StIdle && state_d != StIdle) pnum_q <= pnum_in;
      if (!bus.Capture_En || !bus.data_valid_i) addr_cnt_q <= '0;
      else if (accept)                          addr_cnt_q <= addr_cnt_q + 1'b1;
      s1_valid_q <= accept;
      if (accept) begin
        s1_addr_q  <= addr_cnt_q[AW-1:0];
        s1_data_q  <= bus.data_i;
        s1_first_q <= bus.is_first_pls;
        s1_final_q <= beat_final;
      end
      acc_valid_q <= out_fire;
      if (out_fire) begin
        acc_addr_q <= s1_addr_q;
        acc_data_q <= sum_val;
      end
      done_q <= (state_q == StLast) && (state_d == StDone);
      if (!bus.Capture_En)                      ovf_q <= 1'b0;
      else if (drop || (s1_valid_q && sat))     ovf_q <= 1'b1;
    end
  end

  // Accumulation memory: write-back of the stage-1 sum, synchronous read for new beats.
  always_ff @(posedge clk) begin
    if (s1_valid_q && bus.Capture_En) mem[s1_addr_q] <= sum_val;
    if (accept) rd_q <= mem[addr_cnt_q[AW-1:0]];
  end

  assign bus.acc_valid_o = acc_valid_q;
  assign bus.acc_addr_o  = acc_addr_q;
  assign bus.acc_data_o  = acc_data_q;
  assign bus.acc_done_o  = done_q;
  assign bus.busy_o      = (state_q == StAccum) || (state_q == StLast);
  assign bus.ovf_o       = ovf_q;

endmodule

// File: tb/tb_spectrum_accumulator.sv
// Scoreboard bench for spectrum_accumulator with 4 bins and 8-bit accumulators.
module tb_spectrum_accumulator;
  localparam int DW = 8, AW = 2, ACC_W = 8, NB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spectrum_accumulator_if #(.DW(DW), .AW(AW), .ACC_W(ACC_W)) bus ();

  spectrum_accumulator #(.DW(DW), .AW(AW), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [AW-1:0]    addr;
    logic [ACC_W-1:0] data;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0, tests_failed = 0;
  int   cyc = 0;
  int   model [NB];
  bit   model_ovf;
  int   last_fall;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every final-sum beat must match the oldest expected entry.
  always @(negedge clk) begin
    if (bus.acc_valid_o === 1'b1) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL out_unexpected: got addr=%0d data=%0d cyc=%0d, required no beat",
                 bus.acc_addr_o, bus.acc_data_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.acc_addr_o !== e.addr || bus.acc_data_o !== e.data || cyc != e.cyc) begin
          tests_failed++;
          $display("FAIL out_beat: got addr=%0d data=%0d cyc=%0d, required addr=%0d data=%0d cyc=%0d",
                   bus.acc_addr_o, bus.acc_data_o, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) step();
  endtask

  task automatic start_run(input int pn);
    bus.Capture_En = 1'b0;
    step();
    bus.Pulse_num  = 16'(pn);
    bus.Capture_En = 1'b1;
    model_ovf      = 1'b0;
    step();
  endtask

  // One pulse; cval < 0 means data = bin+1. Final pulses push expected sums.
  task automatic drive_pulse(input int nbeats, input int pc, input bit first, input int cval,
                             input bit final_out, input bit model_on);
    bus.Pulse_counts = 16'(pc);
    bus.is_first_pls = first;
    for (int b = 0; b < nbeats; b++) begin
      int d;
      exp_t e;
      d = (cval < 0) ? b + 1 : cval;
      bus.data_valid_i = 1'b1;
      bus.data_i       = DW'(d);
      if (model_on && b < NB) begin
        model[b] = first ? d : model[b] + d;
        if (model[b] > 255) begin
          model[b]  = 255;
          model_ovf = 1'b1;
        end
        if (final_out) begin
          e.addr = AW'(b);
          e.data = ACC_W'(model[b]);
          e.cyc  = cyc + 2;
          sb.push_back(e);
        end
      end else if (model_on) begin
        model_ovf = 1'b1;
      end
      step();
    end
    bus.data_valid_i = 1'b0;
    last_fall = cyc;
  endtask

  task automatic wait_done();
    int got;
    got = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.acc_done_o === 1'b1) begin
        got = cyc;
        break;
      end
    end
    tests_run++;
    if (got != last_fall + 2) begin
      tests_failed++;
      $display("FAIL done_cycle: got %0d, required %0d", got, last_fall + 2);
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL pending_beats: got %0d outstanding, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    tests_run++;
    if (bus.acc_done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_after: got done=%b busy=%b, required done=0 busy=0",
               bus.acc_done_o, bus.busy_o);
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    gap(2);
    @(negedge clk);
    tests_run++;
    if ({bus.acc_valid_o, bus.acc_addr_o, bus.acc_data_o, bus.acc_done_o, bus.busy_o,
         bus.ovf_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%b a=%0d d=%0d done=%b busy=%b ovf=%b, required all 0",
               bus.acc_valid_o, bus.acc_addr_o, bus.acc_data_o, bus.acc_done_o, bus.busy_o,
               bus.ovf_o);
    end
    step();
    rst = 1'b0;
    gap(2);
  endtask

  task automatic test_accumulate();
    start_run(3);
    drive_pulse(4, 0, 1'b1, -1, 1'b0, 1'b1);
    @(negedge clk);
    tests_run++;
    if (bus.busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_accum: got %b, required 1", bus.busy_o);
    end
    step();
    gap(1);
    drive_pulse(4, 1, 1'b0, -1, 1'b0, 1'b1);
    gap(2);
    drive_pulse(4, 2, 1'b0, -1, 1'b1, 1'b1);
    wait_done();
    tests_run++;
    if (bus.ovf_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL accum_ovf: got %b, required 0", bus.ovf_o);
    end
  endtask

  task automatic test_single_pulse();
    start_run(1);
    drive_pulse(4, 0, 1'b1, 7, 1'b1, 1'b1);
    wait_done();
    drive_pulse(4, 1, 1'b0, 7, 1'b0, 1'b0);
    gap(4);
    tests_run++;
    if (bus.busy_o !== 1'b0 || bus.acc_done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_ignores: got busy=%b done=%b, required 0 0", bus.busy_o, bus.acc_done_o);
    end
  endtask

  task automatic test_saturate();
    start_run(2);
    drive_pulse(4, 0, 1'b1, 200, 1'b0, 1'b1);
    gap(2);
    drive_pulse(4, 1, 1'b0, 200, 1'b1, 1'b1);
    wait_done();
    tests_run++;
    if (bus.ovf_o !== model_ovf) begin
      tests_failed++;
      $display("FAIL sat_ovf: got %b, required %b", bus.ovf_o, model_ovf);
    end
    bus.Capture_En = 1'b0;
    step();
    tests_run++;
    if (bus.ovf_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_clear: got %b, required 0", bus.ovf_o);
    end
  endtask

  task automatic test_overrun();
    start_run(3);
    drive_pulse(6, 0, 1'b1, -1, 1'b0, 1'b1);
    gap(2);
    tests_run++;
    if (bus.ovf_o !== model_ovf) begin
      tests_failed++;
      $display("FAIL overrun_ovf: got %b, required %b", bus.ovf_o, model_ovf);
    end
    drive_pulse(4, 1, 1'b0, -1, 1'b0, 1'b1);
    gap(2);
    drive_pulse(4, 2, 1'b0, -1, 1'b1, 1'b1);
    wait_done();
    tests_run++;
    if (bus.ovf_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_sticky: got %b, required 1", bus.ovf_o);
    end
  endtask

  task automatic test_abort();
    start_run(3);
    drive_pulse(4, 0, 1'b1, 50, 1'b0, 1'b1);
    gap(2);
    bus.Pulse_counts = 16'd1;
    bus.is_first_pls = 1'b0;
    bus.data_valid_i = 1'b1;
    bus.data_i       = DW'(60);
    gap(2);
    bus.Capture_En   = 1'b0;
    bus.data_valid_i = 1'b0;
    gap(3);
    tests_run++;
    if (bus.busy_o !== 1'b0 || bus.ovf_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_idle: got busy=%b ovf=%b, required 0 0", bus.busy_o, bus.ovf_o);
    end
    bus.Pulse_num  = 16'd1;
    bus.Capture_En = 1'b1;
    step();
    drive_pulse(4, 0, 1'b1, -1, 1'b1, 1'b1);
    wait_done();
  endtask

  task automatic test_reset_mid_last();
    exp_t e;
    start_run(1);
    bus.Pulse_counts = 16'd0;
    bus.is_first_pls = 1'b1;
    for (int b = 0; b < 4; b++) begin
      bus.data_valid_i = 1'b1;
      bus.data_i       = DW'(9);
      if (b == 0) begin
        e.addr = '0;
        e.data = ACC_W'(9);
        e.cyc  = cyc + 2;
        sb.push_back(e);
      end
      if (b == 3) begin
        #2 rst = 1'b1;
      end else begin
        step();
      end
    end
    @(negedge clk);
    tests_run++;
    if ({bus.acc_valid_o, bus.acc_addr_o, bus.acc_data_o, bus.acc_done_o, bus.busy_o,
         bus.ovf_o} !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_last: got v=%b a=%0d d=%0d done=%b busy=%b ovf=%b, required all 0",
               bus.acc_valid_o, bus.acc_addr_o, bus.acc_data_o, bus.acc_done_o, bus.busy_o,
               bus.ovf_o);
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL rst_pre_beats: got %0d outstanding, required 0", sb.size());
      sb.delete();
    end
    step();
    rst = 1'b0;
    bus.data_valid_i = 1'b0;
    gap(2);
    drive_pulse(3, 0, 1'b1, 5, 1'b1, 1'b1);
    wait_done();
    tests_run++;
    if (bus.ovf_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_rst_ovf: got %b, required 0", bus.ovf_o);
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.Capture_En   = 1'b0;
    bus.data_valid_i = 1'b0;
    bus.data_i       = '0;
    bus.Pulse_counts = '0;
    bus.is_first_pls = 1'b0;
    bus.Pulse_num    = '0;
    test_reset();
    test_accumulate();
    test_single_pulse();
    test_saturate();
    test_overrun();
    test_abort();
    test_reset_mid_last();
    bus.Capture_En = 1'b0;
    gap(3);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
